// File: rtl/ld_load_arbiter.sv
// Purpose : round-robin arbiter sharing one Load Server back-end between NUM_REQ requesters.
// Latency : request sampled in IDLE at cycle t -> O_Grant/O_Event_Load at t+1; O_Done one cycle after exit.
// Backpr. : no grant while back-end is out of init (I_Sleep=0); grant held until end/abort/watchdog.
//
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   I_Req[NUM_REQ]        - level requests, held until the matching O_Done
//   I_Bypass[NUM_REQ]     - per-requester bypass flag, valid with I_Req
//   I_Sleep               - back-end load controller is in its init state
//   I_End_Load            - back-end end-of-load pulse
//   O_Grant/O_Grant_ID    - registered one-hot grant and its binary index
//   O_Event_Load          - one-cycle load event to the back-end
//   O_Bypass              - registered bypass flag of the granted requester
//   O_Done                - one-cycle completion pulse to the granted requester
//   O_Timeout             - one-cycle pulse when the watchdog forced the release
//   O_Busy                - arbiter not idle
module ld_load_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_REQ = $clog2(NUM_REQ),
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   I_Req,
  input  logic [NUM_REQ-1:0]   I_Bypass,
  input  logic                 I_Sleep,
  input  logic                 I_End_Load,
  output logic [NUM_REQ-1:0]   O_Grant,
  output logic [WIDTH_REQ-1:0] O_Grant_ID,
  output logic                 O_Event_Load,
  output logic                 O_Bypass,
  output logic [NUM_REQ-1:0]   O_Done,
  output logic                 O_Timeout,
  output logic                 O_Busy
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [WIDTH_REQ-1:0] LAST_ID = WIDTH_REQ'(NUM_REQ - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_RUN = 3'd2;
  localparam logic [2:0] S_BUSY     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]           state_q,    state_d;
  logic [NUM_REQ-1:0]   grant_q,    grant_d;
  logic [WIDTH_REQ-1:0] grant_id_q, grant_id_d;
  logic                 bypass_q,   bypass_d;
  logic                 event_q,    event_d;
  logic [NUM_REQ-1:0]   done_q,     done_d;
  logic                 timeout_q,  timeout_d;
  logic [WIDTH_REQ-1:0] ptr_q,      ptr_d;
  logic [WD_W-1:0]      wd_q,       wd_d;

  logic [WIDTH_REQ-1:0] win_id;

  // First set request searching upward from the pointer, wrapping modulo NUM_REQ.
  // The pointer always holds a legal index, so one subtraction is enough to wrap.
  function automatic logic [WIDTH_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0]   req,
    input logic [WIDTH_REQ-1:0] ptr
  );
    logic [WIDTH_REQ-1:0] pick;
    logic                 found;
    int                   idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = WIDTH_REQ'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
    win_id = rr_pick(I_Req, ptr_q);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    bypass_d   = bypass_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    event_d    = 1'b0;
    done_d     = '0;
    timeout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // I_Sleep=0 here means the back-end is still finishing a previous load.
        if ((|I_Req) && I_Sleep) begin
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          grant_id_d = win_id;
          bypass_d   = I_Bypass[win_id];
          event_d    = 1'b1;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_RUN;
      end

      S_WAIT_RUN: begin
        // Leaving init is progress, not completion: the watchdog keeps counting
        // (saturating) so a grant that never ends is still released from BUSY.
        if (!I_Sleep) begin
          state_d = S_BUSY;
          if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
        end else if (wd_q == WD_MAX) begin
          state_d   = S_DONE;
          done_d    = grant_q;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_BUSY: begin
        // A real exit beats the watchdog when both land on the same cycle.
        if (I_End_Load || I_Sleep) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end else if (wd_q == WD_MAX) begin
          state_d   = S_DONE;
          done_d    = grant_q;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_DONE: begin
        // The just-served requester becomes lowest priority.
        ptr_d      = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
        grant_d    = '0;
        grant_id_d = '0;
        bypass_d   = 1'b0;
        wd_d       = '0;
        state_d    = S_IDLE;
      end

      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        bypass_d   = 1'b0;
        wd_d       = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      bypass_q   <= 1'b0;
      event_q    <= 1'b0;
      done_q     <= '0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      bypass_q   <= bypass_d;
      event_q    <= event_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      wd_q       <= wd_d;
    end
  end

  assign O_Grant      = grant_q;
  assign O_Grant_ID   = grant_id_q;
  assign O_Bypass     = bypass_q;
  assign O_Event_Load = event_q;
  assign O_Done       = done_q;
  assign O_Timeout    = timeout_q;
  assign O_Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ld_load_arbiter.sv
// Purpose : scoreboard bench for ld_load_arbiter (NUM_REQ=4, TIMEOUT=16).
// Latency : stimulus pushes expected load events / completions with their cycle numbers.
// Backpr. : a negedge monitor pops and compares whenever O_Event_Load or O_Done/O_Timeout fire.
module tb_ld_load_arbiter;

  localparam int M_END   = 0;
  localparam int M_ABORT = 1;
  localparam int M_WD    = 2;

  logic       clock;
  logic       reset;
  logic [3:0] I_Req;
  logic [3:0] I_Bypass;
  logic       I_Sleep;
  logic       I_End_Load;
  logic [3:0] O_Grant;
  logic [1:0] O_Grant_ID;
  logic       O_Event_Load;
  logic       O_Bypass;
  logic [3:0] O_Done;
  logic       O_Timeout;
  logic       O_Busy;

  ld_load_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .I_Req        (I_Req),
    .I_Bypass     (I_Bypass),
    .I_Sleep      (I_Sleep),
    .I_End_Load   (I_End_Load),
    .O_Grant      (O_Grant),
    .O_Grant_ID   (O_Grant_ID),
    .O_Event_Load (O_Event_Load),
    .O_Bypass     (O_Bypass),
    .O_Done       (O_Done),
    .O_Timeout    (O_Timeout),
    .O_Busy       (O_Busy)
  );

  typedef struct {
    logic [3:0] vec;   // expected grant (event) or done vector
    logic [1:0] id;
    logic       flag;  // bypass for events, timeout for completions
    int         cyc;
  } exp_t;

  exp_t evt_q[$];
  exp_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},   32'(O_Grant),      32'h0);
    chk({tag, "_id"},      32'(O_Grant_ID),   32'h0);
    chk({tag, "_event"},   32'(O_Event_Load), 32'h0);
    chk({tag, "_bypass"},  32'(O_Bypass),     32'h0);
    chk({tag, "_done"},    32'(O_Done),       32'h0);
    chk({tag, "_timeout"}, 32'(O_Timeout),    32'h0);
    chk({tag, "_busy"},    32'(O_Busy),       32'h0);
  endtask

  // Monitor: every output event must match the head of its queue, at the expected cycle.
  always @(negedge clock) begin
    if (reset) begin
      if (O_Event_Load) begin
        if (evt_q.size() == 0) begin
          chk("unexpected_event", 32'(O_Grant), 32'h0);
        end else begin
          exp_t e;
          e = evt_q.pop_front();
          chk("evt_grant",  32'(O_Grant),    32'(e.vec));
          chk("evt_id",     32'(O_Grant_ID), 32'(e.id));
          chk("evt_bypass", 32'(O_Bypass),   32'(e.flag));
          chk("evt_cycle",  32'(cyc),        32'(e.cyc));
        end
      end
      if ((O_Done != 4'h0) || O_Timeout) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'(O_Done), 32'h0);
        end else begin
          exp_t e;
          e = done_q.pop_front();
          chk("done_vec",     32'(O_Done),     32'(e.vec));
          chk("done_timeout", 32'(O_Timeout),  32'(e.flag));
          chk("done_grant",   32'(O_Grant),    32'(e.vec));
          chk("done_id",      32'(O_Grant_ID), 32'(e.id));
          chk("done_cycle",   32'(cyc),        32'(e.cyc));
        end
      end
    end
  end

  // One grant: request in cycle k (IDLE), event at k+1, I_Sleep low from k+1,
  // exit stimulus (end pulse / sleep return / nothing) in cycle k+n+1, O_Done at k+n+2.
  // Returns in the DONE cycle with I_Sleep back to 1.
  task automatic txn(input logic [3:0] req, input logic [3:0] byp, input logic [1:0] exp_id,
                     input logic exp_byp, input int mode, input int n, input bit keep);
    int   k;
    exp_t e;
    k          = cyc;
    I_Req      = req;
    I_Bypass   = byp;
    I_Sleep    = 1'b1;
    I_End_Load = 1'b0;
    e.vec  = 4'b0001 << exp_id;
    e.id   = exp_id;
    e.flag = exp_byp;
    e.cyc  = k + 1;
    evt_q.push_back(e);
    e.flag = (mode == M_WD);
    e.cyc  = k + n + 2;
    done_q.push_back(e);
    tick();
    I_Sleep = 1'b0;
    repeat (n - 1) tick();
    tick();
    if (mode == M_END)   I_End_Load = 1'b1;
    if (mode == M_ABORT) I_Sleep    = 1'b1;
    tick();
    I_End_Load = 1'b0;
    I_Sleep    = 1'b1;
    if (!keep) I_Req = 4'h0;
  endtask

  initial begin
    reset      = 1'b0;
    I_Req      = 4'h0;
    I_Bypass   = 4'h0;
    I_Sleep    = 1'b1;
    I_End_Load = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    tick();

    // Single request to requester 2 with bypass; busy drops the cycle after DONE.
    txn(4'b0100, 4'b0100, 2'd2, 1'b1, M_END, 5, 1'b0);
    tick();
    chk("t1_busy_after", 32'(O_Busy), 32'h0);
    chk("t1_grant_after", 32'(O_Grant), 32'h0);
    chk("t1_id_after", 32'(O_Grant_ID), 32'h0);

    // Pointer is now 3: requests 0,1,3 pending -> 3 wins, not 0.
    txn(4'b1011, 4'b1000, 2'd3, 1'b1, M_END, 2, 1'b0);
    tick();

    // Round robin with all four held: 0,1,2,3,0.
    txn(4'b1111, 4'b0101, 2'd0, 1'b1, M_END, 2, 1'b1); tick();
    txn(4'b1111, 4'b0101, 2'd1, 1'b0, M_END, 2, 1'b1); tick();
    txn(4'b1111, 4'b0101, 2'd2, 1'b1, M_END, 2, 1'b1); tick();
    txn(4'b1111, 4'b0101, 2'd3, 1'b0, M_END, 2, 1'b1); tick();
    txn(4'b1111, 4'b0101, 2'd0, 1'b1, M_END, 2, 1'b0); tick();

    // Back-end busy: request with I_Sleep=0 never grants; pointer 1 wraps to 0.
    I_Req    = 4'b0001;
    I_Bypass = 4'b0000;
    I_Sleep  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_no_grant_busy", 32'(O_Busy), 32'h0);
    end
    txn(4'b0001, 4'b0000, 2'd0, 1'b0, M_END, 3, 1'b0);
    tick();

    // Rename abort: sleep returns with no end pulse.
    txn(4'b0010, 4'b0010, 2'd1, 1'b1, M_ABORT, 4, 1'b0);
    tick();

    // Watchdog: 16 cycles after WAIT_RUN entry, O_Done with O_Timeout.
    txn(4'b0100, 4'b0000, 2'd2, 1'b0, M_WD, 16, 1'b0);
    tick();

    // End pulse on the timeout cycle: exit wins, no timeout.
    txn(4'b1000, 4'b0000, 2'd3, 1'b0, M_END, 16, 1'b0);
    tick();

    // Async reset in BUSY: grant abandoned, no O_Done for it.
    begin
      exp_t e;
      I_Req    = 4'b0010;
      I_Bypass = 4'b0010;
      I_Sleep  = 1'b1;
      e.vec  = 4'b0010;
      e.id   = 2'd1;
      e.flag = 1'b1;
      e.cyc  = cyc + 1;
      evt_q.push_back(e);
      tick();
      I_Sleep = 1'b0;
      tick();
      tick();
      chk("t7_busy_before_reset", 32'(O_Busy), 32'h1);
      #1;
      reset    = 1'b0;
      I_Req    = 4'b1000;
      I_Bypass = 4'b0000;
      #1;
      chk_all_zero("t7_async");
      #1;
      reset   = 1'b1;
      I_Sleep = 1'b1;
    end
    txn(4'b1000, 4'b0000, 2'd3, 1'b0, M_END, 2, 1'b0);
    repeat (3) tick();

    chk("evt_queue_empty", 32'(evt_q.size()), 32'h0);
    chk("done_queue_empty", 32'(done_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
